// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide controller owning the HI/LO registers.
//
// Ports
//   clk, reset        pipeline clock, asynchronous active-high reset
//   start_E, mdop_E   MDU op presented in E (0 none, 1 mult, 2 multu, 3 div,
//                     4 divu, 5 mthi, 6 mtlo, 7 none)
//   rs_E, rt_E        forwarded operands
//   md_use_D          D-stage instruction touches the MDU or HI/LO
//   busy              unit is counting down a mult/div
//   stall_md          combinational stall request to the hazard unit
//   hi, lo            architectural HI/LO
//
// The result is computed at the accepting edge and parked in a pending
// register; the countdown only models the latency seen by the pipeline.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_E,
    input  logic [2:0]  mdop_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic        disc_q, disc_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        is_md, is_div, div_zero;
    logic [63:0] res;
    logic signed [63:0] rs_sx, rt_sx;
    logic signed [31:0] rs_s, rt_s;

    assign is_md    = (mdop_E >= OP_MULT) && (mdop_E <= OP_DIVU);
    assign is_div   = (mdop_E == OP_DIV) || (mdop_E == OP_DIVU);
    assign div_zero = (rt_E == 32'd0);
    assign rs_s     = rs_E;
    assign rt_s     = rt_E;
    assign rs_sx    = {{32{rs_E[31]}}, rs_E};
    assign rt_sx    = {{32{rt_E[31]}}, rt_E};

    // Result datapath, packed as {hi, lo}.
    always_comb begin
        res = 64'd0;
        case (mdop_E)
            OP_MULT:  res = rs_sx * rt_sx;
            OP_MULTU: res = {32'd0, rs_E} * {32'd0, rt_E};
            OP_DIV: begin
                // The most-negative / -1 case overflows the quotient; pin it
                // explicitly rather than rely on simulator/synth behaviour.
                if (div_zero)
                    res = 64'd0;
                else if (rs_E == 32'h8000_0000 && rt_E == 32'hFFFF_FFFF)
                    res = {32'd0, 32'h8000_0000};
                else
                    res = {32'(rs_s % rt_s), 32'(rs_s / rt_s)};
            end
            OP_DIVU: begin
                if (!div_zero)
                    res = {rs_E % rt_E, rs_E / rt_E};
            end
            default: res = 64'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        disc_d  = disc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start_E) begin
                    if (is_md) begin
                        pend_d  = res;
                        disc_d  = is_div && div_zero;
                        cnt_d   = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        state_d = BUSY;
                    end else if (mdop_E == OP_MTHI) begin
                        hi_d = rs_E;
                    end else if (mdop_E == OP_MTLO) begin
                        lo_d = rs_E;
                    end
                end
            end
            BUSY: begin
                // Any start_E seen here is a protocol error and is ignored.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    if (!disc_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            pend_q  <= 64'd0;
            disc_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            disc_q  <= disc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = (state_q == BUSY);
    // Includes the start cycle so a dependent D instruction holds immediately.
    assign stall_md = md_use_D & (busy | (start_E & is_md));
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_E;
    logic [2:0]  mdop_E;
    logic [31:0] rs_E, rt_E;
    logic        md_use_D;
    logic        busy, stall_md;
    logic [31:0] hi, lo;

    int n_chk  = 0;
    int n_pass = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start_E(start_E), .mdop_E(mdop_E),
        .rs_E(rs_E), .rt_E(rt_E), .md_use_D(md_use_D), .busy(busy),
        .stall_md(stall_md), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Called at a negedge with the unit idle. Issues one op, counts busy and
    // stall cycles, returns at the first negedge with busy low. Optionally
    // injects an illegal start on the 2nd busy cycle.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_cyc, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit inject);
        int n = 0;
        int st = 0;
        start_E = 1'b1; mdop_E = op; rs_E = a; rt_E = b;
        #1;
        if (stall_md) st++;
        @(negedge clk);
        start_E = 1'b0; mdop_E = 3'd0;
        while (busy && n < 40) begin
            n++;
            if (stall_md) st++;
            if (inject && n == 2) begin
                start_E = 1'b1; mdop_E = 3'd1; rs_E = 32'd9; rt_E = 32'd9;
            end else begin
                start_E = 1'b0; mdop_E = 3'd0;
            end
            @(negedge clk);
        end
        chk({tag, "_cyc"}, 64'(n), 64'(exp_cyc));
        chk({tag, "_stall"}, 64'(st), md_use_D ? 64'(exp_cyc + 1) : 64'd0);
        chk({tag, "_stall_after"}, {63'd0, stall_md}, 64'd0);
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
        chk({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    endtask

    initial begin
        reset = 1'b1; start_E = 1'b0; mdop_E = 3'd0;
        rs_E = 32'd0; rt_E = 32'd0; md_use_D = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_stall", {63'd0, stall_md}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", {63'd0, busy}, 64'd0);

        run_op("mult",  3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        run_op("div",   3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divovf",3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, 1'b0);

        // mthi / mtlo on consecutive cycles
        start_E = 1'b1; mdop_E = 3'd5; rs_E = 32'h1234_5678;
        @(negedge clk);
        chk("mthi_hi", {32'd0, hi}, 64'h1234_5678);
        chk("mthi_busy", {63'd0, busy}, 64'd0);
        mdop_E = 3'd6; rs_E = 32'h9ABC_DEF0;
        @(negedge clk);
        chk("mtlo_lo", {32'd0, lo}, 64'h9ABC_DEF0);
        chk("mtlo_hi", {32'd0, hi}, 64'h1234_5678);
        chk("mtlo_busy", {63'd0, busy}, 64'd0);

        // divide by zero leaves hi/lo alone
        mdop_E = 3'd5; rs_E = 32'h11;
        @(negedge clk);
        mdop_E = 3'd6; rs_E = 32'h22;
        @(negedge clk);
        start_E = 1'b0; mdop_E = 3'd0;
        run_op("divu0", 3'd4, 32'd7, 32'd0, 10, 32'h11, 32'h22, 1'b0);

        // stall with a dependent D instruction
        md_use_D = 1'b1;
        run_op("divstall", 3'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0);
        md_use_D = 1'b0;

        // back-to-back mult then div, with an illegal mid-BUSY start
        run_op("b2b_mult", 3'd1, 32'd3, 32'd4, 5, 32'd0, 32'd12, 1'b1);
        run_op("b2b_div",  3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b1);

        // reset mid-BUSY clears immediately
        start_E = 1'b1; mdop_E = 3'd1; rs_E = 32'd5; rt_E = 32'd5;
        @(negedge clk);
        start_E = 1'b0; mdop_E = 3'd0;
        @(negedge clk);
        chk("mid_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        chk("rstmid_busy", {63'd0, busy}, 64'd0);
        chk("rstmid_hi", {32'd0, hi}, 64'd0);
        chk("rstmid_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_rst_busy", {63'd0, busy}, 64'd0);
        chk("post_rst_lo", {32'd0, lo}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
